// File: rtl/tod_bcd_ctl.sv
// rtl/tod_bcd_ctl.sv - BCD time-of-day sequencer with 1 ms ticking, PPS realign and PPS-aligned load
//
// Owns the time_t register: nine 4-bit BCD digits packed as
//   [35:32] 10h  [31:28] 1h  [27:24] 10m  [23:20] 1m  [19:16] 10s  [15:12] 1s
//   [11:8] 100ms [7:4] 10ms [3:0] 1ms
//
// Parameters:
//   PPS_ROUND  - 1: PPS with ms >= 500 rounds up to the next second; 0: PPS only clears ms
//   PPS_WIN_MS - PPS arriving with ms in [PPS_WIN_MS, 1000-PPS_WIN_MS) pulses pps_err
//
// Optional feature macro: LEAP_SEC_EN (leap second insertion at midnight via leap_ins)
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   tick_1ms  in   single-cycle strobe, advance time by 1 ms
//   pps       in   single-cycle strobe, second boundary
//   set_req   in   load request level, held until set_ack or set_err
//   set_time  in   time to load (ms digits ignored)
//   set_ack   out  one-cycle pulse, load applied (same cycle as tod update)
//   set_err   out  one-cycle pulse, set_time rejected
//   leap_ins  in   insert leap second at next midnight (LEAP_SEC_EN only)
//   tod       out  current time, registered
//   sec_stb   out  pulse when seconds digits change
//   min_stb   out  pulse when minutes digits change
//   day_stb   out  pulse on wrap to 00:00:00.000
//   valid     out  set by first successful load, cleared only by rst
//   pps_err   out  pulse, PPS outside realign window
module tod_bcd_ctl #(
    parameter int PPS_ROUND  = 1,
    parameter int PPS_WIN_MS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1ms,
    input  logic        pps,
    input  logic        set_req,
    input  logic [35:0] set_time,
    output logic        set_ack,
    output logic        set_err,
    input  logic        leap_ins,
    output logic [35:0] tod,
    output logic        sec_stb,
    output logic        min_stb,
    output logic        day_stb,
    output logic        valid,
    output logic        pps_err
);

    typedef enum logic [1:0] {IDLE, ARMED, WAIT_DROP} state_t;

    localparam logic [9:0] WIN_LO = 10'(PPS_WIN_MS);
    localparam logic [9:0] WIN_HI = 10'(1000 - PPS_WIN_MS);

    state_t state, state_nxt;

    logic [3:0] h10, h1, m10, m1, s10, s1, ms100, ms10, ms1;
    assign {h10, h1, m10, m1, s10, s1, ms100, ms10, ms1} = tod;

    logic [3:0] st_h10, st_h1, st_m10, st_m1, st_s10, st_s1;
    assign {st_h10, st_h1, st_m10, st_m1, st_s10, st_s1} = set_time[35:12];

    logic        set_ok;
    logic        load_now;
    logic        err_now;
    logic [11:0] ms_adv;
    logic        ms_wrap;
    logic [23:0] hms_adv;
    logic        adv_min_chg;
    logic        adv_day_wrap;
    logic [9:0]  ms_val;
    logic        win_err;
    logic        round_up;
    logic        sec_adv;

`ifdef LEAP_SEC_EN
    logic leap_pend;
    logic adv_leap_exit;
    logic unused_bits;
    assign unused_bits = ^set_time[11:0];
`else
    logic unused_bits;
    assign unused_bits = ^{set_time[11:0], leap_ins};
`endif

    // Hours limited to 00-23; ms digits of set_time are not validated.
    assign set_ok = (st_s1 <= 4'd9) && (st_m1 <= 4'd9) && (st_h1 <= 4'd9) &&
                    (st_s10 <= 4'd5) && (st_m10 <= 4'd5) && (st_h10 <= 4'd2) &&
                    !((st_h10 == 4'd2) && (st_h1 > 4'd3));

    // Millisecond ripple increment
    always_comb begin
        ms_adv  = tod[11:0];
        ms_wrap = 1'b0;
        if (ms1 != 4'd9) begin
            ms_adv[3:0] = ms1 + 4'd1;
        end else begin
            ms_adv[3:0] = 4'd0;
            if (ms10 != 4'd9) begin
                ms_adv[7:4] = ms10 + 4'd1;
            end else begin
                ms_adv[7:4] = 4'd0;
                if (ms100 != 4'd9) begin
                    ms_adv[11:8] = ms100 + 4'd1;
                end else begin
                    ms_adv[11:8] = 4'd0;
                    ms_wrap      = 1'b1;
                end
            end
        end
    end

    // One-second advance of the h:m:s digits, shared by tick carry and PPS rounding
    always_comb begin
        hms_adv      = tod[35:12];
        adv_min_chg  = 1'b0;
        adv_day_wrap = 1'b0;
`ifdef LEAP_SEC_EN
        adv_leap_exit = 1'b0;
`endif
        if (s1 != 4'd9) begin
            hms_adv[3:0] = s1 + 4'd1;
        end else begin
            hms_adv[3:0] = 4'd0;
            if (s10 != 4'd5) begin
                hms_adv[7:4] = s10 + 4'd1;
            end else begin
                hms_adv[7:4] = 4'd0;
                adv_min_chg  = 1'b1;
                if (m1 != 4'd9) begin
                    hms_adv[11:8] = m1 + 4'd1;
                end else begin
                    hms_adv[11:8] = 4'd0;
                    if (m10 != 4'd5) begin
                        hms_adv[15:12] = m10 + 4'd1;
                    end else begin
                        hms_adv[15:12] = 4'd0;
                        if ((h10 == 4'd2) && (h1 == 4'd3)) begin
                            hms_adv[23:16] = 8'h00;
                            adv_day_wrap   = 1'b1;
                        end else if (h1 == 4'd9) begin
                            hms_adv[19:16] = 4'd0;
                            hms_adv[23:20] = h10 + 4'd1;
                        end else begin
                            hms_adv[19:16] = h1 + 4'd1;
                        end
                    end
                end
            end
        end
`ifdef LEAP_SEC_EN
        // Leap second: 23:59:59 -> 23:59:60, then 23:59:60 -> 00:00:00
        if (leap_pend && (s10 == 4'd6)) begin
            hms_adv       = 24'h000000;
            adv_min_chg   = 1'b1;
            adv_day_wrap  = 1'b1;
            adv_leap_exit = 1'b1;
        end else if (leap_pend && (tod[35:12] == 24'h235959)) begin
            hms_adv      = 24'h235960;
            adv_min_chg  = 1'b0;
            adv_day_wrap = 1'b0;
        end
`endif
    end

    assign ms_val   = 10'(ms100) * 10'd100 + 10'(ms10) * 10'd10 + 10'(ms1);
    assign win_err  = (ms_val >= WIN_LO) && (ms_val < WIN_HI);
    assign round_up = (PPS_ROUND != 0) && (ms100 >= 4'd5);

    // PPS beats a coincident tick; a PPS-applied load beats realignment.
    assign sec_adv = !load_now && (pps ? round_up : (tick_1ms && ms_wrap));

    // Load FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_now  = 1'b0;
        err_now   = 1'b0;
        case (state)
            IDLE: begin
                if (set_req) begin
                    if (set_ok) begin
                        state_nxt = ARMED;
                    end else begin
                        err_now   = 1'b1;
                        state_nxt = WAIT_DROP;
                    end
                end
            end
            ARMED: begin
                // A withdrawn request wins over a coincident PPS
                if (!set_req) begin
                    state_nxt = IDLE;
                end else if (pps) begin
                    load_now  = 1'b1;
                    state_nxt = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (!set_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Time register and strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            tod     <= 36'h0;
            valid   <= 1'b0;
            sec_stb <= 1'b0;
            min_stb <= 1'b0;
            day_stb <= 1'b0;
            pps_err <= 1'b0;
            set_ack <= 1'b0;
            set_err <= 1'b0;
        end else begin
            sec_stb <= 1'b0;
            min_stb <= 1'b0;
            day_stb <= 1'b0;
            pps_err <= 1'b0;
            set_ack <= load_now;
            set_err <= err_now;
            if (load_now) begin
                tod     <= {set_time[35:12], 12'h000};
                valid   <= 1'b1;
                sec_stb <= (set_time[19:12] != tod[19:12]);
                min_stb <= (set_time[27:20] != tod[27:20]);
            end else if (sec_adv) begin
                tod     <= {hms_adv, 12'h000};
                sec_stb <= 1'b1;
                min_stb <= adv_min_chg;
                day_stb <= adv_day_wrap;
                pps_err <= pps && win_err;
            end else if (pps) begin
                tod[11:0] <= 12'h000;
                pps_err   <= win_err;
            end else if (tick_1ms) begin
                tod[11:0] <= ms_adv;
            end
        end
    end

`ifdef LEAP_SEC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            leap_pend <= 1'b0;
        end else if (leap_ins) begin
            leap_pend <= 1'b1;
        end else if (sec_adv && adv_leap_exit) begin
            leap_pend <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_tod_bcd_ctl.sv
// tb/tb_tod_bcd_ctl.sv - self-checking bench for tod_bcd_ctl
module tb_tod_bcd_ctl;

    logic        clk;
    logic        rst;
    logic        tick_1ms;
    logic        pps;
    logic        set_req;
    logic [35:0] set_time;
    logic        set_ack;
    logic        set_err;
    logic        leap_ins;
    logic [35:0] tod;
    logic        sec_stb;
    logic        min_stb;
    logic        day_stb;
    logic        valid;
    logic        pps_err;

    logic [5:0] flags;
    assign flags = {day_stb, min_stb, sec_stb, pps_err, set_ack, set_err};

    localparam logic [5:0] F_DAY = 6'b100000;
    localparam logic [5:0] F_MIN = 6'b010000;
    localparam logic [5:0] F_SEC = 6'b001000;
    localparam logic [5:0] F_PE  = 6'b000100;
    localparam logic [5:0] F_ACK = 6'b000010;
    localparam logic [5:0] F_ERR = 6'b000001;
    localparam int DAY_MS = 86400000;

    typedef struct {
        logic [35:0] tod;
        logic [5:0]  flags;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks;
    int   n_errors;
    int   cur;

    tod_bcd_ctl #(.PPS_ROUND(1), .PPS_WIN_MS(10)) dut (
        .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .pps(pps),
        .set_req(set_req), .set_time(set_time), .set_ack(set_ack), .set_err(set_err),
        .leap_ins(leap_ins), .tod(tod), .sec_stb(sec_stb), .min_stb(min_stb),
        .day_stb(day_stb), .valid(valid), .pps_err(pps_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] bcd(input int t);
        int h, m, s, ms;
        h  = t / 3600000;
        m  = (t / 60000) % 60;
        s  = (t / 1000) % 60;
        ms = t % 1000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
    endfunction

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600000 + m * 60000 + s * 1000;
    endfunction

    // Expected strobes for a plain 1 ms advance from old to new
    function automatic logic [5:0] tick_flags(input int old_t, input int new_t);
        logic [5:0] f;
        f = 6'b0;
        if ((old_t / 1000) % 60 != (new_t / 1000) % 60) f = f | F_SEC;
        if ((old_t / 60000) % 60 != (new_t / 60000) % 60) f = f | F_MIN;
        if (new_t == 0) f = f | F_DAY;
        return f;
    endfunction

    // Inputs change at the negedge; outputs are observed at the following negedge.
    task automatic cycle(input logic t, input logic p);
        tick_1ms = t;
        pps      = p;
        @(posedge clk);
        @(negedge clk);
        tick_1ms = 1'b0;
        pps      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
    endtask

    task automatic do_load(input logic [35:0] t);
        set_time = t;
        set_req  = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        set_req = 1'b0;
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        n_checks++;
        if (tod !== 36'h0) begin
            n_errors++;
            $display("FAIL reset_tod: got %h expected %h", tod, 36'h0);
        end
        n_checks++;
        if (flags !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected %b", flags, 6'b0);
        end
        n_checks++;
        if (valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: got %b expected 0", valid);
        end
        rst = 1'b0;
        cur = 0;
    endtask

    task automatic test_count;
        int n_sec;
        n_sec = 0;
        for (int i = 0; i < 1000; i++) begin
            sb.push_back('{bcd(cur + 1), tick_flags(cur, cur + 1), "count"});
            cycle(1'b1, 1'b0);
            cur = cur + 1;
            if (sec_stb === 1'b1) n_sec++;
            e = sb.pop_front();
            n_checks++;
            if (tod !== e.tod || flags !== e.flags) begin
                n_errors++;
                $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
            end
        end
        n_checks++;
        if (tod !== 36'h000001000) begin
            n_errors++;
            $display("FAIL count_1s: got %h expected %h", tod, 36'h000001000);
        end
        n_checks++;
        if (n_sec != 1) begin
            n_errors++;
            $display("FAIL count_sec_stb: got %0d pulses expected 1", n_sec);
        end
        n_checks++;
        if (valid !== 1'b0) begin
            n_errors++;
            $display("FAIL count_valid: got %b expected 0", valid);
        end
    endtask

    task automatic test_load;
        // First load changes minutes and seconds; ms digits of set_time are ignored
        set_time = 36'h123400789;
        set_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{bcd(cur), 6'b0, "load_armed_idle"});
            cycle(1'b0, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (tod !== e.tod || flags !== e.flags) begin
                n_errors++;
                $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
            end
        end
        sb.push_back('{36'h123400000, F_SEC | F_MIN | F_ACK, "load_a"});
        sb.push_back('{36'h123400000, 6'b0, "load_a_after"});
        cycle(1'b0, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (tod !== e.tod || flags !== e.flags || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL %s: tod=%h flags=%b valid=%b expected tod=%h flags=%b valid=1", e.name, tod, flags, valid, e.tod, e.flags);
        end
        cycle(1'b0, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (tod !== e.tod || flags !== e.flags) begin
            n_errors++;
            $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
        end
        set_req = 1'b0;
        cycle(1'b0, 1'b0);
        cur = hms(12, 34, 0);
        // ms at .600 before the second load: the load PPS must not round
        ticks(600);
        cur = cur + 600;
        set_time = 36'h123456000;
        set_req  = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        sb.push_back('{36'h123456000, F_SEC | F_ACK, "load_b"});
        cycle(1'b0, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (tod !== e.tod || flags !== e.flags || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL %s: tod=%h flags=%b valid=%b expected tod=%h flags=%b valid=1", e.name, tod, flags, valid, e.tod, e.flags);
        end
        set_req = 1'b0;
        cycle(1'b0, 1'b0);
        cur = hms(12, 34, 56);
        // Request withdrawn while armed: a later PPS is a plain realign
        set_time = 36'h010203000;
        set_req  = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        set_req = 1'b0;
        cycle(1'b0, 1'b0);
        sb.push_back('{bcd(cur), 6'b0, "load_withdrawn"});
        cycle(1'b0, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (tod !== e.tod || flags !== e.flags) begin
            n_errors++;
            $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
        end
    endtask

    task automatic test_wrap_pps;
        int tk[6];
        int base;
        logic [5:0] f;
        tk = '{9, 10, 0, 499, 500, 990};
        do_load(36'h235959000);
        cur = hms(23, 59, 59);
        ticks(999);
        cur = cur + 999;
        n_checks++;
        if (tod !== bcd(cur)) begin
            n_errors++;
            $display("FAIL wrap_pre: got %h expected %h", tod, bcd(cur));
        end
        sb.push_back('{36'h0, F_DAY | F_MIN | F_SEC, "day_wrap"});
        cycle(1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (tod !== e.tod || flags !== e.flags) begin
            n_errors++;
            $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
        end
        cur = 0;
        ticks(600);
        sb.push_back('{bcd(1000), F_SEC | F_PE, "pps_round_600"});
        cycle(1'b1, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (tod !== e.tod || flags !== e.flags) begin
            n_errors++;
            $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
        end
        cur = 1000;
        // Window and rounding boundaries
        for (int k = 0; k < 6; k++) begin
            ticks(tk[k]);
            base = cur;
            f = 6'b0;
            if (tk[k] >= 500) begin
                cur = base + 1000;
                f = f | F_SEC;
            end
            if (tk[k] >= 10 && tk[k] < 990) f = f | F_PE;
            sb.push_back('{bcd(cur), f, $sformatf("pps_at_ms_%0d", tk[k])});
            cycle(1'b0, 1'b1);
            e = sb.pop_front();
            n_checks++;
            if (tod !== e.tod || flags !== e.flags) begin
                n_errors++;
                $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
            end
        end
    endtask

    task automatic test_pps_tick_999;
        ticks(999);
        sb.push_back('{bcd(cur + 1000), F_SEC, "pps_tick_999"});
        sb.push_back('{bcd(cur + 1000), 6'b0, "pps_tick_999_hold"});
        cur = cur + 1000;
        cycle(1'b1, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (tod !== e.tod || flags !== e.flags) begin
            n_errors++;
            $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
        end
        cycle(1'b0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (tod !== e.tod || flags !== e.flags) begin
            n_errors++;
            $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
        end
    endtask

    task automatic test_bad_set;
        logic [35:0] bad[2];
        bad = '{36'h240000000, 36'h12305A000};
        for (int b = 0; b < 2; b++) begin
            set_time = bad[b];
            set_req  = 1'b1;
            sb.push_back('{bcd(cur), F_ERR, $sformatf("bad_set_%0d_err", b)});
            sb.push_back('{bcd(cur), 6'b0, $sformatf("bad_set_%0d_held", b)});
            sb.push_back('{bcd(cur), 6'b0, $sformatf("bad_set_%0d_pps", b)});
            cycle(1'b0, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (tod !== e.tod || flags !== e.flags) begin
                n_errors++;
                $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
            end
            cycle(1'b0, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (tod !== e.tod || flags !== e.flags) begin
                n_errors++;
                $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
            end
            cycle(1'b0, 1'b1);
            e = sb.pop_front();
            n_checks++;
            if (tod !== e.tod || flags !== e.flags) begin
                n_errors++;
                $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
            end
            set_req = 1'b0;
            cycle(1'b0, 1'b0);
        end
        // FSM is back in IDLE: a legal request loads normally
        set_time = 36'h010203000;
        set_req  = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        sb.push_back('{36'h010203000, F_SEC | F_MIN | F_ACK, "good_after_bad"});
        cycle(1'b0, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (tod !== e.tod || flags !== e.flags) begin
            n_errors++;
            $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
        end
        set_req = 1'b0;
        cycle(1'b0, 1'b0);
        cur = hms(1, 2, 3);
    endtask

    task automatic test_leap;
        do_load(36'h235959000);
        leap_ins = 1'b1;
        cycle(1'b0, 1'b0);
        leap_ins = 1'b0;
        ticks(999);
`ifdef LEAP_SEC_EN
        sb.push_back('{36'h235960000, F_SEC, "leap_enter"});
        sb.push_back('{36'h0, F_DAY | F_MIN | F_SEC, "leap_exit"});
`else
        sb.push_back('{36'h0, F_DAY | F_MIN | F_SEC, "no_leap_wrap"});
        sb.push_back('{bcd(1000), F_SEC, "no_leap_next_sec"});
`endif
        cycle(1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (tod !== e.tod || flags !== e.flags) begin
            n_errors++;
            $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
        end
        ticks(999);
        cycle(1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (tod !== e.tod || flags !== e.flags) begin
            n_errors++;
            $display("FAIL %s: tod=%h flags=%b expected tod=%h flags=%b", e.name, tod, flags, e.tod, e.flags);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        tick_1ms = 1'b0;
        pps      = 1'b0;
        set_req  = 1'b0;
        set_time = 36'h0;
        leap_ins = 1'b0;
        @(negedge clk);
        test_reset();
        test_count();
        test_load();
        test_wrap_pps();
        test_pps_tick_999();
        test_bad_set();
        test_leap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tod_bcd_ctl.md
Name: tod_bcd_ctl

Overview:
Time-of-day sequencer for the BCD time structure (hours through milliseconds, nine 4-bit digits). It advances the time on a 1 ms tick and keeps it aligned to the PPS edge. It also accepts a full time load through a req/ack handshake, applied on the next PPS. It sits between the PPS/tick generator and the display and NTP timestamp logic, and is the sole owner of the time_t register.

Parameters:
PPS_ROUND, 1, 1: at PPS, round up to the next second when ms digits >= 500; 0: always clear ms and leave seconds unchanged.
PPS_WIN_MS, 10, PPS realign window in ms; a PPS arriving with ms in [PPS_WIN_MS, 1000-PPS_WIN_MS) sets pps_err.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick_1ms  in  1  single-cycle strobe, advance time by 1 ms
pps  in  1  single-cycle strobe, second boundary
set_req  in  1  load request, level; held until set_ack or set_err
set_time  in  time_t  time to load; ms digits ignored
set_ack  out  1  one-cycle pulse, load applied
set_err  out  1  one-cycle pulse, set_time rejected (illegal BCD or range)
leap_ins  in  1  insert leap second at next midnight (LEAP_SEC_EN only)
tod  out  time_t  current time, registered
sec_stb  out  1  pulse when seconds digits change
min_stb  out  1  pulse when minutes digits change
day_stb  out  1  pulse on wrap to 00:00:00.000
valid  out  1  set by first successful load, cleared only by rst
pps_err  out  1  pulse, PPS outside window

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset: tod all digits 0, valid 0, all strobes, set_ack and set_err 0, FSM IDLE, leap_pend 0.
- Counting: on tick_1ms, ripple-carry increment with tod registered one cycle after the tick. Digit limits are 1ms/10ms/100ms 0-9, 1s 0-9, 10s 0-5, 1m 0-9, 10m 0-5, and hours 00-23 (10h 0-2; 1h 0-9, or 0-3 when 10h=2).
- 23:59:59.999 + tick gives 00:00:00.000 with day_stb, min_stb and sec_stb pulsing in the same cycle as the tod update.
- Counting runs whether or not valid is set.
- PPS realign (no load pending):
  - ms cleared.
  - If PPS_ROUND=1 and ms >= 500, seconds carry as if 1 s elapsed, including full minute/hour/day carry and strobes.
  - If ms == 000 at PPS, no change and no strobe.
- Load FSM:
  - IDLE: when set_req=1, check set_time. Any digit > 9 or out of range for its position, or hour > 23, gives set_err for 1 cycle, then WAIT_DROP. Otherwise go to ARMED.
  - ARMED: on pps, tod <= set_time with ms=000, set_ack pulse, valid <= 1, then WAIT_DROP. No rounding on the load PPS, and sec_stb/min_stb pulse if those digits change.
  - If set_req drops while ARMED, return to IDLE with no ack.
  - WAIT_DROP: wait for set_req=0, then IDLE.
- Simultaneous events:
  - pps and tick_1ms in the same cycle: pps wins and the tick is discarded.
  - Armed load and pps together: load wins over realign.
  - set_time is sampled only in IDLE (validation) and at the load PPS; the requester holds it stable.
- rst mid-load aborts the FSM to IDLE with no ack.

Optional Feature:
LEAP_SEC_EN
- Defined:
  - leap_ins=1 in any cycle sets leap_pend.
  - While leap_pend, 23:59:59.999 + tick gives 23:59:60.000 (10s digit = 6), sec_stb only.
  - The next wrap from 23:59:60.999 gives 00:00:00.000 with day_stb and clears leap_pend.
  - PPS rounding from :60 follows the same path.
- Undefined: leap_ins is ignored, there is no leap_pend register, and 10s never exceeds 5.

Test Plan:
- rst, then 1000 ticks -> tod=00:00:01.000, sec_stb exactly once, valid=0.
- set_req with 12:34:56 and a pps 3 cycles later -> set_ack on the load cycle, tod=12:34:56.000, valid=1, min_stb=0.
- tod=23:59:59.999 + tick -> 00:00:00.000, day_stb=min_stb=sec_stb=1 in the same cycle; pps with tick at .600 (PPS_ROUND=1) -> seconds +1, ms=000, pps_err=1.
- set_time hour=24, or a digit 0xA -> set_err pulse, tod unchanged, no set_ack, FSM waits for set_req low.
- pps and tick_1ms together at .999 -> ms=000, seconds +1 once, not twice.
- LEAP_SEC_EN, leap_ins, run through midnight -> 23:59:60.000 then 00:00:00.000 one second later; without the macro -> direct wrap at 23:59:59.999.
